adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 114 +++++++++++
 tb/tb_adder_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester front end sharing one ripple-carry adder; round-robin grant,
// one transaction in flight, result held until the consumer accepts it.

module riple_carry_adder #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  output logic [WIDTH:0]   o_result
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    o_result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_result[i] = i_add_term1[i] ^ i_add_term2[i] ^ carry[i];
      carry[i+1]  = (i_add_term1[i] & i_add_term2[i]) |
                    (i_add_term1[i] & carry[i]) |
                    (i_add_term2[i] & carry[i]);
    end
    o_result[WIDTH] = carry[WIDTH];
  end

endmodule

module adder_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_req1_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_result_id,
  output logic             o_result_valid,
  input  logic             i_result_ready
);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESULT} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             grant0, grant1;
  logic             xfer;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum;

  riple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .i_add_term1 (op_a),
    .i_add_term2 (op_b),
    .o_result    (sum)
  );

  // Readies are gated by reset so nothing is offered while i_rst_n is low.
  always_comb begin
    grant0       = i_req0_valid && (!i_req1_valid || !ptr);
    grant1       = i_req1_valid && (!i_req0_valid ||  ptr);
    o_req0_ready = i_rst_n && (state == IDLE) && grant0;
    o_req1_ready = i_rst_n && (state == IDLE) && grant1;
    xfer         = o_req0_ready || o_req1_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = COMPUTE;
      COMPUTE: state_nxt = RESULT;
      RESULT:  if (i_result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr            <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      o_result       <= '0;
      o_result_id    <= 1'b0;
      o_result_valid <= 1'b0;
    end else begin
      if (xfer) begin
        op_a        <= o_req1_ready ? i_req1_a : i_req0_a;
        op_b        <= o_req1_ready ? i_req1_b : i_req0_b;
        o_result_id <= o_req1_ready;
        // Pointer moves to the requester that was not granted.
        ptr         <= o_req0_ready;
      end
      if (state == COMPUTE) begin
        o_result       <= sum;
        o_result_valid <= 1'b1;
      end else if (state == RESULT && i_result_ready) begin
        o_result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (WIDTH=2): vector table plus
// hand-written reset, back-pressure and round-robin sequences.

module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ready0, ready1;
  logic [2:0] result;
  logic       result_id, result_valid;
  logic       rr = 1'b1;

  adder_arbiter #(.WIDTH(2)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req0_valid   (valid0),
    .i_req0_a       (a0),
    .i_req0_b       (b0),
    .o_req0_ready   (ready0),
    .i_req1_valid   (valid1),
    .i_req1_a       (a1),
    .i_req1_b       (b1),
    .o_req1_ready   (ready1),
    .o_result       (result),
    .o_result_id    (result_id),
    .o_result_valid (result_valid),
    .i_result_ready (rr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;
    logic       id;
    int         t;
  } sb_t;

  typedef struct {
    int         n0;
    logic [1:0] a0, b0;
    int         n1;
    logic [1:0] a1, b1;
    logic [2:0] s0, s1;
  } vec_t;

  sb_t  q[$];
  vec_t tbl[8];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic model_ptr = 1'b0;
  logic held = 1'b0, prev_v = 1'b0;
  logic [2:0] h_res;
  logic       h_id;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting on the DUT (t=%0t)", name, $time);
  endtask

  // Result monitor: ordering, hold stability, latency and ready exclusivity.
  always @(negedge clk) begin
    if (!rst_n) begin
      held   = 1'b0;
      prev_v = 1'b0;
    end else begin
      chk("ready_overlap", int'(ready0 & ready1), 0);
      if (held) begin
        chk("hold_valid", int'(result_valid), 1);
        chk("hold_result", int'(result), int'(h_res));
        chk("hold_id", int'(result_id), int'(h_id));
      end
      if (result_valid && !prev_v) begin
        if (q.size() == 0) chk("spurious_valid", int'(result_valid), 0);
        else chk("latency", cyc - q[0].t, 2);
      end
      if (result_valid && rr) begin
        if (q.size() == 0) begin
          chk("unexpected_result", int'(result_valid), 0);
        end else begin
          sb_t e;
          e = q.pop_front();
          chk("result", int'(result), int'(e.res));
          chk("result_id", int'(result_id), int'(e.id));
        end
      end
      held   = result_valid && !rr;
      h_res  = result;
      h_id   = result_id;
      prev_v = result_valid;
    end
  end

  // Presents n0/n1 transactions, holding each valid until all its transfers
  // have happened; the expected grant order comes from a pointer model.
  task automatic issue(input int n0, input logic [1:0] ia0, input logic [1:0] ib0,
                       input int n1, input logic [1:0] ia1, input logic [1:0] ib1,
                       input logic [2:0] s0, input logic [2:0] s1);
    int   p0 = n0;
    int   p1 = n1;
    int   budget = 0;
    logic exp_id;
    @(posedge clk); #1;
    valid0 = (p0 > 0); a0 = ia0; b0 = ib0;
    valid1 = (p1 > 0); a1 = ia1; b1 = ib1;
    while ((p0 > 0 || p1 > 0) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (ready0 || ready1) begin
        exp_id = (p0 > 0 && p1 > 0) ? model_ptr : (p0 > 0 ? 1'b0 : 1'b1);
        chk("grant_id", int'(ready1), int'(exp_id));
        if (ready1) begin
          q.push_back('{res: s1, id: 1'b1, t: cyc});
          p1--;
          model_ptr = 1'b0;
        end else begin
          q.push_back('{res: s0, id: 1'b0, t: cyc});
          p0--;
          model_ptr = 1'b1;
        end
      end
      @(posedge clk); #1;
      valid0 = (p0 > 0);
      valid1 = (p1 > 0);
    end
    if (p0 > 0 || p1 > 0) timeout("issue");
  endtask

  task automatic drain();
    int budget = 0;
    while (q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() != 0) begin
      timeout("drain");
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{1, 2'd2, 2'd1, 1, 2'd1, 2'd3, 3'd3, 3'd4};
    tbl[1] = '{1, 2'd3, 2'd3, 0, 2'd0, 2'd0, 3'd6, 3'd0};
    tbl[2] = '{0, 2'd0, 2'd0, 1, 2'd3, 2'd1, 3'd0, 3'd4};
    tbl[3] = '{1, 2'd3, 2'd2, 1, 2'd0, 2'd1, 3'd5, 3'd1};
    tbl[4] = '{0, 2'd0, 2'd0, 1, 2'd0, 2'd0, 3'd0, 3'd0};
    tbl[5] = '{1, 2'd1, 2'd2, 0, 2'd0, 2'd0, 3'd3, 3'd0};
    tbl[6] = '{1, 2'd1, 2'd1, 1, 2'd3, 2'd3, 3'd2, 3'd6};
    tbl[7] = '{1, 2'd2, 2'd2, 1, 2'd0, 2'd3, 3'd4, 3'd3};

    // Reset with both requesters asserting: outputs zero, no readies.
    #2 rst_n = 1'b0;
    valid0 = 1'b1; valid1 = 1'b1;
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_id", int'(result_id), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_ready0", int'(ready0), 0);
    chk("rst_ready1", int'(ready1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; valid0 = 1'b0; valid1 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].n0, tbl[i].a0, tbl[i].b0, tbl[i].n1, tbl[i].a1, tbl[i].b1,
            tbl[i].s0, tbl[i].s1);
      drain();
    end

    // Reset asserted while the transaction is in COMPUTE.
    valid0 = 1'b1; a0 = 2'd1; b0 = 2'd1;
    @(negedge clk);
    chk("pre_rst_ready0", int'(ready0), 1);
    @(posedge clk); #1;
    valid0 = 1'b0;
    #2 rst_n = 1'b0;
    valid0 = 1'b1;
    #1;
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_valid", int'(result_valid), 0);
    chk("mid_rst_id", int'(result_id), 0);
    chk("mid_rst_ready0", int'(ready0), 0);
    @(negedge clk);
    rst_n = 1'b1; valid0 = 1'b0;
    model_ptr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_valid", int'(result_valid), 0);
    end

    // Both held valid for four transactions: grants alternate 0,1,0,1.
    issue(2, 2'd1, 2'd2, 2, 2'd3, 2'd2, 3'd3, 3'd5);
    drain();

    // Consumer stalls five cycles in RESULT; a pending requester is not readied.
    rr = 1'b0;
    issue(1, 2'd2, 2'd2, 0, 2'd0, 2'd0, 3'd4, 3'd0);
    begin
      int budget = 0;
      while (!result_valid && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!result_valid) timeout("wait_result");
    end
    @(posedge clk); #1;
    valid1 = 1'b1; a1 = 2'd1; b1 = 2'd1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready0", int'(ready0), 0);
      chk("stall_ready1", int'(ready1), 0);
      chk("stall_valid", int'(result_valid), 1);
    end
    @(posedge clk); #1;
    rr = 1'b1;
    valid1 = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
